pipe_mux_nto1: RTL

- Parametrised, registered N-to-1 datapath selector with valid/ready handshakes; successor to the fixed 32-bit 3-input combinational mux.
- Used in the pipelined datapath wherever multiple producers share one consumer, e.g. writeback source selection and operand forwarding.
- Two modes:
  - Fixed-select: software/decoder chooses the source.
  - Round-robin: fair arbitration among valid sources.
- One output register stage; full throughput.

---
 rtl/pipe_mux_nto1.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipe_mux_nto1.sv
// Registered N-to-1 selector with valid/ready handshakes: fixed-select or round-robin source choice.
// Optional backpressure counter on stall_cnt is built only when PIPE_MUX_STALL_CNT_EN is defined.
module pipe_mux_nto1 #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic [15:0]             stall_cnt
);

    // Valid/ready: a word moves on any edge where valid and ready are both high.
    // A producer holds valid and data until that edge; ready may depend on valid
    // combinationally, valid never depends on ready.

    localparam int NSLOT = 1 << SEL_W;

    if (NUM_IN < 2 || NUM_IN > 16 || NSLOT < NUM_IN) begin : g_bad_params
        $error("pipe_mux_nto1: NUM_IN must be 2..16 and fit in SEL_W bits");
    end

    logic [NSLOT-1:0]  valid_pad;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  rr_cand;
    logic              rr_found;
    logic [NUM_IN-1:0] grant;
    logic              load_en;
    logic              xfer;
    logic [WIDTH-1:0]  mux_data;
    logic [SEL_W-1:0]  mux_src;

    assign valid_pad = NSLOT'(in_valid);

    // Round-robin scan starts just after the last winner, wrapping at NUM_IN.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            rr_cand = SEL_W'((int'(rr_ptr) + k) % NUM_IN);
            if (!rr_found && valid_pad[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // An out-of-range sel matches no channel, so it grants nothing.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (mode) begin
                grant[i] = rr_found && (rr_idx == SEL_W'(i));
            end else begin
                grant[i] = in_valid[i] && (sel == SEL_W'(i));
            end
        end
    end

    assign load_en  = !out_valid || out_ready;
    assign in_ready = grant & {NUM_IN{load_en}};
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        mux_data = '0;
        mux_src  = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                mux_data = mux_data | in_data[i*WIDTH +: WIDTH];
                mux_src  = mux_src | SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            out_src   <= mux_src;
            if (mode) begin
                rr_ptr <= mux_src;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PIPE_MUX_STALL_CNT_EN
    logic [15:0] stall_q;

    // Counts cycles a word sits unconsumed; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
